// File: rtl/time_keeper_ar.sv
// time_keeper_ar: day/hour/minute/second keeper driven by the system clock.
// Set mode steps each field in either direction, with per-button auto-repeat.
// Also provides a 12-hour display hour, a PM flag and a one-clock seconds strobe.
// Optional alarm compare is enabled by defining TIME_KEEPER_ALARM_EN.
module time_keeper_ar #(
    parameter int unsigned G_CLK_FREQ = 20000,
    parameter int unsigned G_BTN_INIT = 20000,
    parameter int unsigned G_BTN_HOLD = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_set_time_n,
    input  logic       i_dir,
    input  logic       i_incr_day_n,
    input  logic       i_incr_hr_n,
    input  logic       i_incr_min_n,
`ifdef TIME_KEEPER_ALARM_EN
    input  logic [4:0] i_alarm_hour,
    input  logic [5:0] i_alarm_minute,
    input  logic [6:0] i_alarm_days,
`endif
    output logic [6:0] o_day,
    output logic [4:0] o_hour,
    output logic [3:0] o_hour_12,
    output logic       o_pm,
    output logic [5:0] o_minute,
    output logic [5:0] o_second,
    output logic       o_sec_tick,
    output logic       o_setting,
    output logic       o_alarm
);

    localparam int unsigned DIV_W   = $clog2(G_CLK_FREQ);
    localparam int unsigned CNT_MAX = (G_BTN_INIT > G_BTN_HOLD) ? G_BTN_INIT : G_BTN_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(G_CLK_FREQ - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(G_BTN_INIT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(G_BTN_HOLD - 1);

    // Synchroniser bit order: {set_time_n, dir, day_n, hr_n, min_n}.
    // Reset loads the idle panel levels so no step or set mode is seen out of reset.
    localparam logic [4:0] SYNC_IDLE = 5'b10111;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_FIRST,
        BTN_REPEAT
    } btn_state_t;

    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic             set_mode;
    logic             dir_dec;
    logic [2:0]       pressed;
    logic [2:0]       step;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_d;
    logic [5:0]       sec_d;
    logic [5:0]       min_d;
    logic [4:0]       hr_d;
    logic [6:0]       day_d;
`ifdef TIME_KEEPER_ALARM_EN
    logic             alarm_d;
`endif

    function automatic logic [3:0] to_12h(input logic [4:0] h);
        if (h == 5'd0)
            return 4'd12;
        else if (h <= 5'd12)
            return h[3:0];
        else
            return 4'(h - 5'd12);
    endfunction

    // Two-stage synchronisers for all five front-panel inputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= {i_set_time_n, i_dir, i_incr_day_n, i_incr_hr_n, i_incr_min_n};
            sync2 <= sync1;
        end
    end

    assign set_mode = ~sync2[4];
    assign dir_dec  = sync2[3];
    assign pressed  = ~sync2[2:0];

    // Index 0 = minute, 1 = hour, 2 = day
    for (genvar b = 0; b < 3; b++) begin : g_btn
        btn_state_t       state_q;
        btn_state_t       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             step_b;

        // Auto-repeat state and interval counter register
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                state_q <= BTN_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Auto-repeat next state: step on press, after the initial delay, then every hold period
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            step_b  = 1'b0;
            if (!set_mode || !pressed[b]) begin
                state_d = BTN_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    BTN_IDLE: begin
                        step_b  = 1'b1;
                        state_d = BTN_FIRST;
                        cnt_d   = '0;
                    end
                    BTN_FIRST: begin
                        if (cnt_q == INIT_LAST) begin
                            step_b  = 1'b1;
                            state_d = BTN_REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    BTN_REPEAT: begin
                        if (cnt_q == HOLD_LAST) begin
                            step_b = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = BTN_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign step[b] = step_b;
    end

    // Next time value: field stepping in set mode, divider and carry chain in run mode
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        sec_d  = o_second;
        min_d  = o_minute;
        hr_d   = o_hour;
        day_d  = o_day;
`ifdef TIME_KEEPER_ALARM_EN
        alarm_d = 1'b0;
`endif
        if (set_mode) begin
            div_d = '0;
            sec_d = '0;
            if (step[0]) begin
                if (dir_dec)
                    min_d = (o_minute == 6'd0) ? 6'd59 : o_minute - 6'd1;
                else
                    min_d = (o_minute == 6'd59) ? 6'd0 : o_minute + 6'd1;
            end
            if (step[1]) begin
                if (dir_dec)
                    hr_d = (o_hour == 5'd0) ? 5'd23 : o_hour - 5'd1;
                else
                    hr_d = (o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1;
            end
            if (step[2]) begin
                if (dir_dec)
                    day_d = {o_day[0], o_day[6:1]};
                else
                    day_d = {o_day[5:0], o_day[6]};
            end
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
            if (o_second == 6'd59) begin
                sec_d = '0;
                if (o_minute == 6'd59) begin
                    min_d = '0;
                    if (o_hour == 5'd23) begin
                        hr_d  = '0;
                        day_d = {o_day[5:0], o_day[6]};
                    end else begin
                        hr_d = o_hour + 5'd1;
                    end
                end else begin
                    min_d = o_minute + 6'd1;
                end
`ifdef TIME_KEEPER_ALARM_EN
                alarm_d = (hr_d == i_alarm_hour) && (min_d == i_alarm_minute) &&
                          ((day_d & i_alarm_days) != 7'd0);
`endif
            end else begin
                sec_d = o_second + 6'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Time, display and strobe registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_q      <= '0;
            o_sec_tick <= 1'b0;
            o_second   <= '0;
            o_minute   <= '0;
            o_hour     <= '0;
            o_day      <= 7'b0000001;
            o_hour_12  <= 4'd12;
            o_pm       <= 1'b0;
            o_setting  <= 1'b0;
        end else begin
            div_q      <= div_d;
            o_sec_tick <= tick_d;
            o_second   <= sec_d;
            o_minute   <= min_d;
            o_hour     <= hr_d;
            o_day      <= day_d;
            o_hour_12  <= to_12h(hr_d);
            o_pm       <= (hr_d >= 5'd12);
            o_setting  <= set_mode;
        end
    end

`ifdef TIME_KEEPER_ALARM_EN
    // Alarm pulse register, aligned with the seconds strobe
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_alarm <= 1'b0;
        else
            o_alarm <= alarm_d;
    end
`else
    assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper_ar.sv
// Directed testbench for time_keeper_ar (G_CLK_FREQ=5, G_BTN_INIT=5, G_BTN_HOLD=1).
module tb_time_keeper_ar;

    localparam int unsigned F = 5;
    localparam int unsigned I = 5;
    localparam int unsigned H = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_n;
    logic       dir;
    logic       day_n;
    logic       hr_n;
    logic       min_n;
    logic [6:0] day;
    logic [4:0] hour;
    logic [3:0] hour_12;
    logic       pm;
    logic [5:0] minute;
    logic [5:0] second;
    logic       sec_tick;
    logic       setting;
    logic       alarm;
`ifdef TIME_KEEPER_ALARM_EN
    logic [4:0] a_hour;
    logic [5:0] a_min;
    logic [6:0] a_days;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_min;
    logic        exp_alarm;

    always #5 clk = ~clk;

    time_keeper_ar #(
        .G_CLK_FREQ(F),
        .G_BTN_INIT(I),
        .G_BTN_HOLD(H)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_set_time_n(set_n),
        .i_dir       (dir),
        .i_incr_day_n(day_n),
        .i_incr_hr_n (hr_n),
        .i_incr_min_n(min_n),
`ifdef TIME_KEEPER_ALARM_EN
        .i_alarm_hour  (a_hour),
        .i_alarm_minute(a_min),
        .i_alarm_days  (a_days),
`endif
        .o_day       (day),
        .o_hour      (hour),
        .o_hour_12   (hour_12),
        .o_pm        (pm),
        .o_minute    (minute),
        .o_second    (second),
        .o_sec_tick  (sec_tick),
        .o_setting   (setting),
        .o_alarm     (alarm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_day"}, day, 7'b0000001);
        check({tag, "_hour"}, hour, 0);
        check({tag, "_hour12"}, hour_12, 12);
        check({tag, "_pm"}, pm, 0);
        check({tag, "_min"}, minute, 0);
        check({tag, "_sec"}, second, 0);
        check({tag, "_tick"}, sec_tick, 0);
        check({tag, "_setting"}, setting, 0);
        check({tag, "_alarm"}, alarm, 0);
    endtask

    // Single press held for one clock: exactly one step lands two edges later.
    task automatic tap(input int unsigned which);
        case (which)
            0: min_n = 1'b0;
            1: hr_n  = 1'b0;
            default: day_n = 1'b0;
        endcase
        step_clk(1);
        min_n = 1'b1;
        hr_n  = 1'b1;
        day_n = 1'b1;
        step_clk(4);
    endtask

    initial begin
        rst   = 1'b1;
        set_n = 1'b1;
        dir   = 1'b0;
        day_n = 1'b1;
        hr_n  = 1'b1;
        min_n = 1'b1;
`ifdef TIME_KEEPER_ALARM_EN
        a_hour = 5'd0;
        a_min  = 6'd1;
        a_days = 7'b0000001;
`endif
        #1;
        check_reset("por");
        step_clk(2);
        check_reset("rst_held");
        rst = 1'b0;

        // Free run from reset: tick every 5 clocks, one minute after 300 clocks
        for (int j = 1; j <= 300; j++) begin
            step_clk(1);
            check("run_tick", sec_tick, (j % 5 == 0));
`ifdef TIME_KEEPER_ALARM_EN
            exp_alarm = (j == 300);
`else
            exp_alarm = 1'b0;
`endif
            check("run_alarm", alarm, exp_alarm);
        end
        check("run_min", minute, 1);
        check("run_sec", second, 0);
        check("run_hour", hour, 0);
        check("run_day", day, 7'b0000001);
        check("run_setting", setting, 0);

        // Reset, then decrement taps: hour 0->23, minute 0->59, day Sun->Sat
        rst = 1'b1;
        #1;
        check_reset("rst2");
        step_clk(1);
        rst   = 1'b0;
        set_n = 1'b0;
        dir   = 1'b1;
        step_clk(2);
        check("enter_setting_early", setting, 0);
        step_clk(1);
        check("enter_setting", setting, 1);
        step_clk(2);
        tap(1);
        check("dec_hour", hour, 23);
        check("dec_hour12", hour_12, 11);
        check("dec_pm", pm, 1);
        check("dec_min_untouched", minute, 0);
        tap(0);
        check("dec_min", minute, 59);
        check("dec_min_hour", hour, 23);
        tap(2);
        check("dec_day", day, 7'b1000000);
        check("dec_sec", second, 0);

        // Exit set mode at Sat 23:59; 60th tick rolls over to Sun 00:00
        set_n = 1'b1;
        dir   = 1'b0;
        for (int j = 1; j <= 302; j++) begin
            step_clk(1);
            check("exit_tick", sec_tick, (j >= 7) && ((j - 7) % 5 == 0));
            check("exit_alarm", alarm, 0);
            if (j == 2) check("exit_setting_hold", setting, 1);
            if (j == 3) check("exit_setting_clr", setting, 0);
            if (j == 301) begin
                check("pre_wrap_day", day, 7'b1000000);
                check("pre_wrap_hour", hour, 23);
                check("pre_wrap_min", minute, 59);
                check("pre_wrap_sec", second, 59);
            end
        end
        check("wrap_day", day, 7'b0000001);
        check("wrap_hour", hour, 0);
        check("wrap_min", minute, 0);
        check("wrap_sec", second, 0);
        check("wrap_pm", pm, 0);
        check("wrap_hour12", hour_12, 12);

        // Held minute button: steps at k, k+5, k+6..k+10 (k = 3rd edge after press)
        rst = 1'b1;
        #1;
        check_reset("rst3");
        step_clk(1);
        rst   = 1'b0;
        set_n = 1'b0;
        step_clk(5);
        check("hold_setting", setting, 1);
        min_n = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step_clk(1);
            if (j < 3)       exp_min = 0;
            else if (j < 8)  exp_min = 1;
            else if (j < 13) exp_min = j - 6;
            else             exp_min = 7;
            check("hold_min", minute, exp_min);
            if (j == 11) min_n = 1'b1;
        end
        check("hold_hour", hour, 0);
        check("hold_sec", second, 0);
        check("hold_day", day, 7'b0000001);

        // Reset while in REPEAT: immediate return to reset values, no later step
        min_n = 1'b0;
        step_clk(10);
        check("repeat_min", minute, 11);
        rst = 1'b1;
        #1;
        check_reset("rst_repeat");
        min_n = 1'b1;
        step_clk(2);
        check_reset("rst_repeat_held");
        rst = 1'b0;
        step_clk(10);
        check("post_rst_min", minute, 0);
        check("post_rst_setting", setting, 1);

`ifdef TIME_KEEPER_ALARM_EN
        // Day mask excludes Sunday: no alarm at 00:01
        set_n  = 1'b1;
        a_days = 7'b0000010;
        rst    = 1'b1;
        step_clk(1);
        rst = 1'b0;
        for (int j = 1; j <= 300; j++) begin
            step_clk(1);
            check("mask_alarm", alarm, 0);
        end
        check("mask_min", minute, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
